// File: rtl/fft384_pkg.sv
// Shared constants and width rules for the 384-point FFT twiddle-multiply stage.
// Twiddles are Q2.14: sign, one integer bit, fourteen fraction bits.
package fft384_pkg;

  localparam int unsigned N_PT  = 384;
  localparam int unsigned CNT_W = 9;

  localparam logic [15:0] ONE   = 16'h4000;
  localparam logic [15:0] M_ONE = 16'hC000;
  localparam logic [15:0] C45   = 16'h2D41;

  // A full-precision data x twiddle product.
  function automatic int unsigned prod_w(input int unsigned d_w, input int unsigned tw_w);
    return d_w + tw_w;
  endfunction

  // Sum or difference of two products needs one extra bit.
  function automatic int unsigned sum_w(input int unsigned d_w, input int unsigned tw_w);
    return d_w + tw_w + 1;
  endfunction

endpackage

// File: rtl/cmult_rnd_sat.sv
// Two-stage complex multiply: registered partial products, then
// combine, round half up, saturate, and register back to data width.
module cmult_rnd_sat
  import fft384_pkg::*;
#(
  parameter int unsigned D_W  = 16,
  parameter int unsigned TW_W = 16,
  parameter int unsigned FRAC = 14
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   vld_i,
  input  logic                   sop_i,
  input  logic signed [D_W-1:0]  re_i,
  input  logic signed [D_W-1:0]  im_i,
  input  logic signed [TW_W-1:0] cos_i,
  input  logic signed [TW_W-1:0] sin_i,
  output logic                   vld_o,
  output logic                   sop_o,
  output logic signed [D_W-1:0]  re_o,
  output logic signed [D_W-1:0]  im_o
);

  localparam int unsigned PW = prod_w(D_W, TW_W);
  localparam int unsigned SW = sum_w(D_W, TW_W);
  localparam logic signed [SW-1:0] HALF = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = {{(SW-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [PW-1:0] rc_q, ps_q, rs_q, pc_q;
  logic                 s1_vld_q, s1_sop_q;
  logic signed [SW-1:0] yr, yi, yr_sh, yi_sh;
  logic signed [D_W-1:0] re_d, im_d, re_q, im_q;
  logic                 vld_q, sop_q;

  function automatic logic signed [D_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MAXV)      return MAXV[D_W-1:0];
    else if (v < MINV) return MINV[D_W-1:0];
    else               return v[D_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rc_q     <= '0;
      ps_q     <= '0;
      rs_q     <= '0;
      pc_q     <= '0;
      s1_vld_q <= 1'b0;
      s1_sop_q <= 1'b0;
    end else begin
      rc_q     <= PW'(re_i) * PW'(cos_i);
      ps_q     <= PW'(im_i) * PW'(sin_i);
      rs_q     <= PW'(re_i) * PW'(sin_i);
      pc_q     <= PW'(im_i) * PW'(cos_i);
      s1_vld_q <= vld_i;
      s1_sop_q <= sop_i;
    end
  end

  // Arithmetic shift after adding HALF is floor((y + 2^(FRAC-1)) / 2^FRAC).
  always_comb begin
    yr    = SW'(rc_q) - SW'(ps_q);
    yi    = SW'(rs_q) + SW'(pc_q);
    yr_sh = (yr + HALF) >>> FRAC;
    yi_sh = (yi + HALF) >>> FRAC;
    re_d  = re_q;
    im_d  = im_q;
    if (s1_vld_q) begin
      re_d = sat(yr_sh);
      im_d = sat(yi_sh);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      re_q  <= '0;
      im_q  <= '0;
      vld_q <= 1'b0;
      sop_q <= 1'b0;
    end else begin
      re_q  <= re_d;
      im_q  <= im_d;
      vld_q <= s1_vld_q;
      sop_q <= s1_sop_q;
    end
  end

  assign re_o  = re_q;
  assign im_o  = im_q;
  assign vld_o = vld_q;
  assign sop_o = sop_q;

endmodule

// File: rtl/fft384_twiddle_mult.sv
// Twiddle-multiply stage: carrier counter driving the twiddle ROM, one-cycle
// sample delay to meet the ROM word, complex multiply, misalignment flag.
module fft384_twiddle_mult #(
  parameter int unsigned D_W  = 16,
  parameter int unsigned TW_W = 16,
  parameter int unsigned N_PT = 384,
  parameter int unsigned FRAC = 14
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic [D_W-1:0]    din_re,
  input  logic [D_W-1:0]    din_im,
  output logic [8:0]        rom_num,
  output logic              rom_vld,
  input  logic [2*TW_W-1:0] tw,
  input  logic              tw_vld,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic [D_W-1:0]    dout_re,
  output logic [D_W-1:0]    dout_im,
  output logic              align_err
);
  import fft384_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sop_err;
  logic             s0_vld_q, s0_sop_q, s0_serr_q;
  logic [D_W-1:0]   s0_re_q, s0_im_q;
  logic             align_err_q;

  // A sop always restarts the carrier index, even mid-frame.
  always_comb begin
    rom_num = din_sop ? '0 : cnt_q;
    cnt_d   = cnt_q;
    if (din_vld) begin
      cnt_d = (rom_num == CNT_W'(N_PT - 1)) ? '0 : rom_num + 1'b1;
    end
    sop_err = din_vld & din_sop & (cnt_q != '0);
  end

  assign rom_vld = din_vld;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q       <= '0;
      s0_vld_q    <= 1'b0;
      s0_sop_q    <= 1'b0;
      s0_serr_q   <= 1'b0;
      s0_re_q     <= '0;
      s0_im_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s0_vld_q    <= din_vld;
      s0_sop_q    <= din_sop & din_vld;
      s0_serr_q   <= sop_err;
      s0_re_q     <= din_re;
      s0_im_q     <= din_im;
      align_err_q <= s0_vld_q & (~tw_vld | s0_serr_q);
    end
  end

  assign align_err = align_err_q;

  cmult_rnd_sat #(
    .D_W  (D_W),
    .TW_W (TW_W),
    .FRAC (FRAC)
  ) u_cmult (
    .clk   (clk),
    .n_rst (n_rst),
    .vld_i (s0_vld_q),
    .sop_i (s0_sop_q),
    .re_i  (s0_re_q),
    .im_i  (s0_im_q),
    .cos_i (tw[2*TW_W-1:TW_W]),
    .sin_i (tw[TW_W-1:0]),
    .vld_o (dout_vld),
    .sop_o (dout_sop),
    .re_o  (dout_re),
    .im_o  (dout_im)
  );

endmodule

// File: tb/tb_fft384_twiddle_mult.sv
// Scoreboard bench for the twiddle-multiply stage; the bench also plays the
// one-cycle twiddle ROM, returning whatever word the stimulus chose per sample.
module tb_fft384_twiddle_mult;
  import fft384_pkg::*;

  localparam longint SCALE = 16384;
  localparam longint HALFS = 8192;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        din_vld, din_sop;
  logic [15:0] din_re, din_im;
  logic [8:0]  rom_num;
  logic        rom_vld;
  logic [31:0] tw = '0;
  logic        tw_vld = 1'b0;
  logic        dout_vld, dout_sop;
  logic [15:0] dout_re, dout_im;
  logic        align_err;

  always #5 clk = ~clk;

  fft384_twiddle_mult #(
    .D_W  (16),
    .TW_W (16),
    .N_PT (384),
    .FRAC (14)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .din_vld   (din_vld),
    .din_sop   (din_sop),
    .din_re    (din_re),
    .din_im    (din_im),
    .rom_num   (rom_num),
    .rom_vld   (rom_vld),
    .tw        (tw),
    .tw_vld    (tw_vld),
    .dout_vld  (dout_vld),
    .dout_sop  (dout_sop),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .align_err (align_err)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        sop;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          vec = 0, mis = 0, cyc = 0;
  int          ref_cnt = 0, ae_exp = 0, ae_seen = 0;
  logic [31:0] tw_pend = '0;
  bit          tw_en = 1'b1;
  logic [15:0] last_re = '0, last_im = '0;

  // Twiddle ROM stand-in: word and valid arrive one cycle after the request.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    tw     <= tw_pend;
    tw_vld <= din_vld & tw_en;
  end

  task automatic chk(input string name, input longint act, input longint req);
    vec++;
    if (act != req) begin
      mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint rnd_div(input longint y);
    longint q;
    q = y + HALFS;
    return (q >= 0) ? q / SCALE : -((-q + SCALE - 1) / SCALE);
  endfunction

  function automatic int clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       return -32768;
      1:       return 32767;
      default: return int'($signed(r));
    endcase
  endfunction

  function automatic logic [31:0] rnd_tw();
    case ($urandom_range(0, 5))
      0:       return {ONE, 16'h0000};
      1:       return {M_ONE, M_ONE};
      2:       return {C45, C45};
      default: return $urandom();
    endcase
  endfunction

  task automatic drive(input bit v, input bit sop, input int re, input int im,
                       input logic [31:0] twv, input bit twen);
    int     num;
    longint c, s, yr, yi;
    exp_t   e;
    @(negedge clk);
    din_vld = v;
    din_sop = sop;
    din_re  = re[15:0];
    din_im  = im[15:0];
    tw_pend = twv;
    tw_en   = twen;
    num     = sop ? 0 : ref_cnt;
    #1;
    chk("rom_num", longint'(rom_num), longint'(num));
    chk("rom_vld", longint'(rom_vld), longint'(v));
    if (v) begin
      if ((sop && ref_cnt != 0) || !twen) ae_exp++;
      ref_cnt = (num == int'(N_PT) - 1) ? 0 : num + 1;
      c  = longint'($signed(twv[31:16]));
      s  = longint'($signed(twv[15:0]));
      yr = longint'(re) * c - longint'(im) * s;
      yi = longint'(re) * s + longint'(im) * c;
      e.re  = 16'(clamp16(rnd_div(yr)));
      e.im  = 16'(clamp16(rnd_div(yi)));
      e.sop = sop;
      e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 32'h0, 1'b1);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_align_err_pulses"}, longint'(ae_seen), longint'(ae_exp));
    chk({tag, "_outputs_drained"}, longint'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!n_rst) begin
      last_re = '0;
      last_im = '0;
    end else begin
      if (align_err) ae_seen++;
      if (dout_vld) begin
        if (sb.size() == 0) begin
          chk("dout_vld_unexpected", longint'(dout_vld), 0);
        end else begin
          e = sb.pop_front();
          chk("dout_re", longint'($signed(dout_re)), longint'($signed(e.re)));
          chk("dout_im", longint'($signed(dout_im)), longint'($signed(e.im)));
          chk("dout_sop", longint'(dout_sop), longint'(e.sop));
          chk("latency", longint'(cyc - e.cyc), 3);
        end
        last_re = dout_re;
        last_im = dout_im;
      end else begin
        chk("hold_re", longint'(dout_re), longint'(last_re));
        chk("hold_im", longint'(dout_im), longint'(last_im));
      end
    end
  end

  initial begin
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_re  = '0;
    din_im  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout_vld", longint'(dout_vld), 0);
    chk("rst_dout_sop", longint'(dout_sop), 0);
    chk("rst_dout_re", longint'(dout_re), 0);
    chk("rst_dout_im", longint'(dout_im), 0);
    chk("rst_align_err", longint'(align_err), 0);
    chk("rst_rom_num", longint'(rom_num), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Full frame plus one: index wraps 383 -> 0, sop only on the first output
    for (int i = 0; i < 385; i++) drive(1'b1, i == 0, rnd16(), rnd16(), rnd_tw(), 1'b1);
    idle(6);
    checkpoint("wrap");

    drive(1'b1, 1'b0, 1000, -2000, {ONE, 16'h0000}, 1'b1);
    idle(4);
    drive(1'b1, 1'b0, 10000, 0, {C45, C45}, 1'b1);
    drive(1'b1, 1'b0, 300, 500, {16'h0000, ONE}, 1'b1);
    drive(1'b1, 1'b0, -32768, -32768, {M_ONE, 16'h0000}, 1'b1);
    drive(1'b1, 1'b0, 32767, 0, {M_ONE, 16'h0000}, 1'b1);
    idle(6);
    checkpoint("directed");

    for (int i = 0; i < 20; i++) drive(i % 2 == 0, 1'b0, rnd16(), rnd16(), rnd_tw(), 1'b1);
    idle(4);
    checkpoint("bubbles");

    while (ref_cnt != 57) drive(1'b1, 1'b0, rnd16(), rnd16(), rnd_tw(), 1'b1);
    drive(1'b1, 1'b1, rnd16(), rnd16(), rnd_tw(), 1'b1);
    idle(6);
    checkpoint("sop_mid_frame");

    drive(1'b1, 1'b0, 1234, -4321, {C45, M_ONE}, 1'b0);
    idle(6);
    checkpoint("tw_vld_low");

    for (int i = 0; i < 300; i++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      drive(v, v && ($urandom_range(0, 49) == 0), rnd16(), rnd16(), rnd_tw(),
            $urandom_range(0, 19) != 0);
    end
    idle(6);
    checkpoint("random");

    // Reset with two samples in flight: nothing may emerge afterwards
    drive(1'b1, 1'b0, rnd16(), rnd16(), rnd_tw(), 1'b1);
    drive(1'b1, 1'b0, rnd16(), rnd16(), rnd_tw(), 1'b1);
    @(negedge clk);
    n_rst   = 1'b0;
    din_vld = 1'b0;
    #1;
    chk("midrst_dout_vld", longint'(dout_vld), 0);
    chk("midrst_dout_re", longint'(dout_re), 0);
    chk("midrst_dout_im", longint'(dout_im), 0);
    chk("midrst_align_err", longint'(align_err), 0);
    sb.delete();
    ref_cnt = 0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    idle(6);
    checkpoint("mid_reset");
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, rnd16(), rnd16(), rnd_tw(), 1'b1);
    idle(6);
    checkpoint("post_reset_frame");

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/fft384_twiddle_mult.md
Name: fft384_twiddle_mult

Overview:
- Twiddle-multiply stage of the 384-point FFT datapath.
- Per input sample it:
  - generates the carrier index 0..383 and issues it to the twiddle ROM decoder;
  - delays the sample to align with the ROM's 1-cycle lookup;
  - performs a pipelined complex multiply, then rounds and saturates back to data width.
- Sits between the butterfly/reorder stage and the next FFT radix stage; owns the ROM address side and consumes the {cos,sin} word.

Parameters:
- D_W, 16, signed width of data I/Q in and out.
- TW_W, 16, signed twiddle component width, Q2.14 (sign, 1 integer bit, 14 fraction bits).
- N_PT, 384, carrier count per frame; counter wraps at N_PT-1.
- FRAC, 14, twiddle fraction bits; product right-shift amount.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- din_vld  in  1  input sample valid.
- din_sop  in  1  first sample of frame; qualified by din_vld.
- din_re  in  D_W  input real part, two's complement.
- din_im  in  D_W  input imaginary part, two's complement.
- rom_num  out  9  carrier index to the ROM decoder; combinational from counter/sop.
- rom_vld  out  1  = din_vld, combinational.
- tw  in  2*TW_W  {cos,sin} from the ROM, valid one cycle after rom_num.
- tw_vld  in  1  ROM valid, one cycle after rom_vld.
- dout_vld  out  1  output valid.
- dout_sop  out  1  delayed din_sop.
- dout_re  out  D_W  product real part.
- dout_im  out  D_W  product imaginary part.
- align_err  out  1  one-cycle pulse on pipeline/ROM misalignment.

Behaviour:
- Reset: counter=0; all pipeline registers, dout_vld, dout_sop, dout_re, dout_im and align_err = 0.
- Counter cnt[8:0]:
  - rom_num = din_sop ? 0 : cnt.
  - On a din_vld cycle: cnt <= (rom_num==N_PT-1) ? 0 : rom_num+1.
  - No din_vld: cnt holds, so bubbles are allowed anywhere in a frame.
  - din_sop while cnt!=0: counter is forced to 0 and align_err pulses on the S1 cycle.
- Pipeline, with the sample presented in cycle t:
  - S0 (end of t): register din_re, din_im, vld, sop. The ROM latches rom_num at the same edge.
  - S1 (end of t+1): tw is valid in t+1. Register the four products:
    - pr_rc = re*cos
    - pi_s = im*sin
    - pr_s = re*sin
    - pi_c = im*cos
    - Each is signed, D_W+TW_W bits.
  - S2 (end of t+2):
    - yr = pr_rc - pi_s; yi = pr_s + pi_c (D_W+TW_W+1 bits).
    - Add 2^(FRAC-1), arithmetic shift right by FRAC (round half up).
    - Saturate to [-2^(D_W-1), 2^(D_W-1)-1].
    - Register to dout_re/dout_im with vld and sop.
- Latency: exactly 3 cycles from din_vld to dout_vld. Full throughput of 1 sample/clk.
- dout_re/dout_im hold their last value when dout_vld=0.
- Misalignment: S0 vld=1 with tw_vld=0 in the same cycle -> align_err pulses for 1 cycle; the sample is still processed.
- Reset mid-frame: the pipeline is flushed with no output. The next frame must start with din_sop; without it the counter starts at 0 anyway.

Decomposition:
- Shared package fft384_pkg holds:
  - N_PT = 384;
  - Q2.14 constants ONE = 16'h4000, M_ONE = 16'hC000, C45 = 16'h2D41;
  - the round/saturate width rules.
- One natural sub-module, cmult_rnd_sat: stages S1/S2, parameterised on D_W/TW_W/FRAC.
- The counter, alignment delay and error check stay in the top.

Test Plan:
- Identity: tw={4000,0000}, din=(1000,-2000) -> dout=(1000,-2000) exactly 3 cycles after din_vld; dout_vld high 1 cycle.
- Rotation: tw={2D41,2D41}, din=(10000,0) -> dout=(7071,7071); tw={0000,4000}, din=(300,500) -> dout=(-500,300).
- Saturation: tw={C000,0000}, din=(-32768,-32768) -> dout=(32767,32767); din=(32767,0) -> (-32767,0).
- Counter wrap: 385 back-to-back valids with din_sop on the first -> rom_num 0,1,...,383,0; dout_sop high only on the first output; align_err never set.
- Bubbles and sop: din_vld toggling 1010... -> rom_num advances only on valid cycles. din_sop at cnt=57 -> rom_num=0 that cycle, align_err pulses once.
- Reset: assert n_rst low mid-frame with 2 samples in flight -> outputs 0 immediately, no dout_vld after release; the next sop frame starts rom_num at 0. Separately, holding tw_vld=0 -> align_err pulses.
